fetch_pipe: RTL and testbench
=============================

FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 Parameter IMEM_DEPTH, 2048, instruction memory size in bytes; SHALL be a power of two, at least 16.
REQ-002 Parameter AW, $clog2(IMEM_DEPTH), write-address width.
REQ-003 Parameter CNT_W, 32, width of fetch_count.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 F_stall  in  1  hold the F register (predicted PC).
REQ-007 D_stall  in  1  hold the D register.
REQ-008 D_bubble  in  1  load a bubble into the D register.
REQ-009 M_icode  in  4  icode in the memory stage.
REQ-010 M_cnd  in  1  branch condition in the memory stage.
REQ-011 M_valA  in  64  fall-through PC of the mispredicted jump.
REQ-012 W_icode  in  4  icode in the write-back stage.
REQ-013 W_valM  in  64  return address.
REQ-014 imem_we  in  1  instruction-memory byte write enable.
REQ-015 imem_waddr  in  AW  write address.
REQ-016 imem_wdata  in  8  write data.
REQ-017 D_stat, D_icode, D_ifun, D_rA, D_rB  out  4 each  D pipeline register fields.
REQ-018 D_valC, D_valP  out  64 each  D pipeline register fields.
REQ-019 F_predPC  out  64  F register value.
REQ-020 halted  out  1  fetch frozen after a non-AOK fetch.
REQ-021 fetch_count  out  CNT_W  count of real instructions loaded into D.

Function
REQ-022 f_PC SHALL be M_valA when M_icode=7 and M_cnd=0; else W_valM when W_icode=9; else F_predPC. This is the priority order. "Redirect" means either of the first two cases.
REQ-023 Instruction bytes SHALL be read combinationally at f_PC..f_PC+9. Bytes at addresses >= IMEM_DEPTH read as 0.
REQ-024 Length by icode:
- 0, 1, 9: 1 byte
- 2, 6, A, B: 2 bytes
- 3, 4, 5: 10 bytes
- 7, 8: 9 bytes
- f_valP = f_PC + length, 64-bit wrap.
REQ-025 rA/rB SHALL be byte f_PC+1 high/low nibble for icodes 2-6, A, B; otherwise 0xF.
REQ-026 valC SHALL be 8 bytes with the lowest address most significant:
- starts at f_PC+2 for icodes 3-5;
- starts at f_PC+1 for icodes 7-8;
- otherwise 0.
REQ-027 f_stat SHALL be assigned in this priority:
- ADR (3) if f_PC+length-1 >= IMEM_DEPTH or f_PC >= IMEM_DEPTH;
- else INS (4) if icode > 0xB;
- else HLT (2) if icode = 0;
- else AOK (1).
REQ-028 On ADR, the icode/ifun latched into D SHALL be forced to 1/0.
REQ-029 Predicted PC SHALL be f_valC for icodes 7 and 8; otherwise f_valP.
REQ-030 F register update: F_predPC loads the predicted PC each edge unless F_stall=1, or halted=1 with no redirect.
REQ-031 D register priority is rst_n low, then D_stall (hold), then D_bubble (bubble), then halted with no redirect (bubble), then load fetched fields.
REQ-032 Bubble value: stat 1, icode 1, ifun 0, rA F, rB F, valC 0, valP 0.
REQ-033 halted SHALL set on the edge that loads a non-AOK f_stat into D.
REQ-034 halted SHALL clear on any edge where a redirect is present. That same edge fetches normally from the redirect PC; set and clear never coincide because the redirect path wins.
REQ-035 fetch_count SHALL increment by 1 on each edge that loads fetched fields into D (REQ-031 last case) and SHALL saturate at all-ones.
REQ-036 Memory write SHALL occur on the edge when imem_we=1, independent of rst_n. A read in the same cycle returns the old byte. Memory contents are never cleared.
REQ-037 Output state changes SHALL occur on clock edges only; no $finish or simulation-control side effects.

Reset
REQ-038 With rst_n=0 at an edge, outputs SHALL take these values:
- F_predPC=0, halted=0, fetch_count=0;
- D register = bubble (REQ-032).
REQ-039 Reset SHALL override stall, bubble and redirect; the first fetch after release SHALL be from address 0.

Verification
REQ-040 Memory 30 F3 00 00 00 00 00 00 00 0A at 0, reset released -> first edge: D_icode=3, D_rB=3, D_valC=0x0A, D_valP=10, F_predPC=10, fetch_count=1.
REQ-041 jXX at 0x20, target 0x40 -> F_predPC=0x40. Next cycle drive M_icode=7, M_cnd=0, M_valA=0x29 -> D holds the instruction from 0x29.
REQ-042 F_stall=D_stall=1 for 2 cycles -> F_predPC, all D fields and fetch_count unchanged.
REQ-043 Byte 00 at 5, PC reaches 5:
- D_stat=2, halted=1, F_predPC=6, later D loads are bubbles;
- then drive W_icode=9, W_valM=0 -> halted=0, D holds the instruction at 0.
REQ-044 irmovq placed at IMEM_DEPTH-4 -> D_stat=3, D_icode=1, halted=1.
REQ-045 rst_n=0 for one edge mid-program with D_bubble=1 and a redirect present -> reset values of REQ-038, then fetch from 0.

Source files
------------

// File: rtl/fetch_pipe.sv
// fetch_pipe -- fetch stage and D pipeline register of a Y86-64 style pipeline.
//
// Selects the fetch PC (mispredicted-branch fall-through, return address, or
// the predicted PC), reads a 10-byte instruction window from a byte-wide
// instruction memory, splits it into fields, predicts the next PC and latches
// the result into the D register. A non-AOK fetch freezes the stage until a
// redirect arrives.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   F_stall               hold the predicted-PC register
//   D_stall, D_bubble     hold / bubble the D register
//   M_icode, M_cnd, M_valA  memory-stage jump info (mispredict redirect)
//   W_icode, W_valM       write-back-stage ret info (return redirect)
//   imem_we/waddr/wdata   instruction-memory byte write port
//   D_*                   D pipeline register fields
//   F_predPC              predicted PC register
//   halted                fetch frozen after a non-AOK fetch
//   fetch_count           saturating count of real instructions loaded into D
module fetch_pipe #(
   parameter int IMEM_DEPTH = 2048,
   parameter int AW         = $clog2(IMEM_DEPTH),
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             F_stall,
   input  logic             D_stall,
   input  logic             D_bubble,
   input  logic [3:0]       M_icode,
   input  logic             M_cnd,
   input  logic [63:0]      M_valA,
   input  logic [3:0]       W_icode,
   input  logic [63:0]      W_valM,
   input  logic             imem_we,
   input  logic [AW-1:0]    imem_waddr,
   input  logic [7:0]       imem_wdata,
   output logic [3:0]       D_stat,
   output logic [3:0]       D_icode,
   output logic [3:0]       D_ifun,
   output logic [3:0]       D_rA,
   output logic [3:0]       D_rB,
   output logic [63:0]      D_valC,
   output logic [63:0]      D_valP,
   output logic [63:0]      F_predPC,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   localparam logic [3:0] S_AOK = 4'd1;
   localparam logic [3:0] S_HLT = 4'd2;
   localparam logic [3:0] S_ADR = 4'd3;
   localparam logic [3:0] S_INS = 4'd4;

   // Addresses are formed one bit wider than the PC so that a window running
   // past 2^64 is still seen as out of range instead of wrapping to low memory.
   localparam logic [64:0] DEPTH_X = 65'(IMEM_DEPTH);

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
   } dreg_t;

   localparam dreg_t BUBBLE = '{stat: S_AOK, icode: 4'h1, ifun: 4'h0,
                                ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0};

   // ---------------------------------------------------------------------
   // Instruction memory: written on any edge with imem_we (reset does not
   // gate it), read asynchronously so same-cycle reads see the old byte.
   // ---------------------------------------------------------------------
   logic [7:0] mem [IMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (imem_we) mem[imem_waddr] <= imem_wdata;
   end

   // ---------------------------------------------------------------------
   // Fetch PC selection: mispredicted jump first, then ret, then prediction.
   // ---------------------------------------------------------------------
   logic        redirect;
   logic [63:0] f_pc;

   always_comb begin
      redirect = 1'b1;
      f_pc     = F_predPC;
      if (M_icode == 4'h7 && !M_cnd)
         f_pc = M_valA;
      else if (W_icode == 4'h9)
         f_pc = W_valM;
      else
         redirect = 1'b0;
   end

   // ---------------------------------------------------------------------
   // 10-byte instruction window; bytes beyond the memory read as zero.
   // ---------------------------------------------------------------------
   logic [9:0][7:0] ib;

   for (genvar i = 0; i < 10; i++) begin : g_rd
      logic [64:0] addr;
      assign addr  = {1'b0, f_pc} + 65'(i);
      assign ib[i] = (addr < DEPTH_X) ? mem[addr[AW-1:0]] : 8'h00;
   end

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   logic [3:0]  f_icode, f_ifun, f_ra, f_rb, f_len, f_stat;
   logic [63:0] f_valc, f_valp, f_pred;
   logic        need_regs;
   logic [64:0] last_byte;
   logic        adr_err;

   assign f_icode = ib[0][7:4];
   assign f_ifun  = ib[0][3:0];

   always_comb begin
      f_len = 4'd1;
      case (f_icode)
         4'h0, 4'h1, 4'h9:       f_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
         4'h3, 4'h4, 4'h5:       f_len = 4'd10;
         4'h7, 4'h8:             f_len = 4'd9;
         default:                f_len = 4'd1;
      endcase
   end

   always_comb begin
      need_regs = 1'b0;
      case (f_icode)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regs = 1'b1;
         default:                                  need_regs = 1'b0;
      endcase
   end

   assign f_ra = need_regs ? ib[1][7:4] : 4'hF;
   assign f_rb = need_regs ? ib[1][3:0] : 4'hF;

   // Constant words are stored with the lowest address as the most
   // significant byte.
   always_comb begin
      f_valc = 64'd0;
      case (f_icode)
         4'h3, 4'h4, 4'h5:
            f_valc = {ib[2], ib[3], ib[4], ib[5], ib[6], ib[7], ib[8], ib[9]};
         4'h7, 4'h8:
            f_valc = {ib[1], ib[2], ib[3], ib[4], ib[5], ib[6], ib[7], ib[8]};
         default:
            f_valc = 64'd0;
      endcase
   end

   assign f_valp    = f_pc + 64'(f_len);
   assign last_byte = {1'b0, f_pc} + 65'(f_len) - 65'd1;
   assign adr_err   = ({1'b0, f_pc} >= DEPTH_X) || (last_byte >= DEPTH_X);

   always_comb begin
      if (adr_err)
         f_stat = S_ADR;
      else if (f_icode > 4'hB)
         f_stat = S_INS;
      else if (f_icode == 4'h0)
         f_stat = S_HLT;
      else
         f_stat = S_AOK;
   end

   // jXX and call are predicted taken.
   assign f_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valc : f_valp;

   // Fetched fields as they would enter D; an address fault shows as a nop.
   dreg_t d_fetch;

   always_comb begin
      d_fetch.stat  = f_stat;
      d_fetch.icode = adr_err ? 4'h1 : f_icode;
      d_fetch.ifun  = adr_err ? 4'h0 : f_ifun;
      d_fetch.ra    = f_ra;
      d_fetch.rb    = f_rb;
      d_fetch.valc  = f_valc;
      d_fetch.valp  = f_valp;
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   dreg_t d_q;
   logic  frozen;   // halted and nothing to pull us out this cycle
   logic  d_load;   // real instruction enters D this edge

   assign frozen = halted && !redirect;
   assign d_load = !D_stall && !D_bubble && !frozen;

   always_ff @(posedge clk) begin
      if (!rst_n)
         F_predPC <= 64'd0;
      else if (!F_stall && !frozen)
         F_predPC <= f_pred;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         d_q <= BUBBLE;
      else if (D_stall)
         d_q <= d_q;
      else if (D_bubble || frozen)
         d_q <= BUBBLE;
      else
         d_q <= d_fetch;
   end

   // A redirect always clears, even if the redirected fetch itself is bad;
   // that fault is caught on the following edge.
   always_ff @(posedge clk) begin
      if (!rst_n)
         halted <= 1'b0;
      else if (redirect)
         halted <= 1'b0;
      else if (d_load && f_stat != S_AOK)
         halted <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         fetch_count <= '0;
      else if (d_load && fetch_count != '1)
         fetch_count <= fetch_count + 1'b1;
   end

   assign D_stat  = d_q.stat;
   assign D_icode = d_q.icode;
   assign D_ifun  = d_q.ifun;
   assign D_rA    = d_q.ra;
   assign D_rB    = d_q.rb;
   assign D_valC  = d_q.valc;
   assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_fetch_pipe.sv
module tb_fetch_pipe;
   localparam int DEPTH = 2048;
   localparam int AW    = 11;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, F_stall = 1'b0, D_stall = 1'b0, D_bubble = 1'b0;
   logic [3:0]    M_icode = 4'h0, W_icode = 4'h0;
   logic          M_cnd = 1'b0;
   logic [63:0]   M_valA = 64'd0, W_valM = 64'd0;
   logic          imem_we = 1'b0;
   logic [AW-1:0] imem_waddr = '0;
   logic [7:0]    imem_wdata = 8'h00;

   logic [3:0]    D_stat, D_icode, D_ifun, D_rA, D_rB;
   logic [63:0]   D_valC, D_valP, F_predPC;
   logic          halted;
   logic [CW-1:0] fetch_count;

   fetch_pipe #(.IMEM_DEPTH(DEPTH), .AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall),
      .D_bubble(D_bubble), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
      .W_icode(W_icode), .W_valM(W_valM), .imem_we(imem_we),
      .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA),
      .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .F_predPC(F_predPC),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [7:0]    mm [DEPTH];
   logic [7:0]    img [DEPTH];
   logic [63:0]   e_pred = 64'd0;
   logic          e_halt = 1'b0;
   logic [CW-1:0] e_cnt = '0;
   logic [3:0]    e_stat = 4'd1, e_icode = 4'd1, e_ifun = 4'd0, e_ra = 4'hF, e_rb = 4'hF;
   logic [63:0]   e_valc = 64'd0, e_valp = 64'd0;

   function automatic logic [7:0] rd(input logic [64:0] a);
      if (a < 65'(DEPTH)) return mm[a[AW-1:0]];
      return 8'h00;
   endfunction

   // Compute what the next edge must produce from the current inputs, let the
   // edge happen, commit the model, and return at the following negedge.
   task automatic step();
      logic [63:0] pc, vc, vp, np;
      logic [64:0] pcx, last;
      logic [7:0]  b0, b1, wd;
      logic [3:0]  ic, st, ra, rb;
      logic [AW-1:0] wa;
      logic redir, ld, we;
      int len, vstart;
      redir = 1'b1;
      if (M_icode == 4'h7 && !M_cnd) pc = M_valA;
      else if (W_icode == 4'h9) pc = W_valM;
      else begin pc = e_pred; redir = 1'b0; end
      pcx = {1'b0, pc};
      b0 = rd(pcx);
      b1 = rd(pcx + 65'd1);
      ic = b0[7:4];
      if (ic inside {4'h0, 4'h1, 4'h9}) len = 1;
      else if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) len = 2;
      else if (ic inside {4'h3, 4'h4, 4'h5}) len = 10;
      else if (ic inside {4'h7, 4'h8}) len = 9;
      else len = 1;
      if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
         ra = b1[7:4]; rb = b1[3:0];
      end else begin
         ra = 4'hF; rb = 4'hF;
      end
      vstart = (ic inside {4'h3, 4'h4, 4'h5}) ? 2 : (ic inside {4'h7, 4'h8}) ? 1 : 0;
      vc = 64'd0;
      if (vstart != 0)
         for (int k = 0; k < 8; k++) vc = (vc << 8) | 64'(rd(pcx + 65'(vstart + k)));
      vp = pc + 64'(len);
      last = pcx + 65'(len) - 65'd1;
      if (pcx >= 65'(DEPTH) || last >= 65'(DEPTH)) st = 4'd3;
      else if (ic > 4'hB) st = 4'd4;
      else if (ic == 4'h0) st = 4'd2;
      else st = 4'd1;
      np = (ic inside {4'h7, 4'h8}) ? vc : vp;
      ld = !D_stall && !D_bubble && !(e_halt && !redir);
      we = imem_we; wa = imem_waddr; wd = imem_wdata;
      @(posedge clk);
      if (!rst_n) begin
         e_pred = 64'd0; e_halt = 1'b0; e_cnt = '0;
         e_stat = 4'd1; e_icode = 4'd1; e_ifun = 4'd0; e_ra = 4'hF; e_rb = 4'hF;
         e_valc = 64'd0; e_valp = 64'd0;
      end else begin
         if (!F_stall && !(e_halt && !redir)) e_pred = np;
         if (!D_stall) begin
            if (ld) begin
               e_stat = st;
               e_icode = (st == 4'd3) ? 4'h1 : ic;
               e_ifun = (st == 4'd3) ? 4'h0 : b0[3:0];
               e_ra = ra; e_rb = rb; e_valc = vc; e_valp = vp;
               if (e_cnt != {CW{1'b1}}) e_cnt = e_cnt + 1'b1;
            end else begin
               e_stat = 4'd1; e_icode = 4'd1; e_ifun = 4'd0; e_ra = 4'hF; e_rb = 4'hF;
               e_valc = 64'd0; e_valp = 64'd0;
            end
         end
         if (redir) e_halt = 1'b0;
         else if (ld && st != 4'd1) e_halt = 1'b1;
      end
      if (we) mm[wa] = wd;
      @(negedge clk);
   endtask

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("m_stat", {60'd0, D_stat}, {60'd0, e_stat});
         chk("m_icode", {60'd0, D_icode}, {60'd0, e_icode});
         chk("m_ifun", {60'd0, D_ifun}, {60'd0, e_ifun});
         chk("m_rA", {60'd0, D_rA}, {60'd0, e_ra});
         chk("m_rB", {60'd0, D_rB}, {60'd0, e_rb});
         chk("m_valC", D_valC, e_valc);
         chk("m_valP", D_valP, e_valp);
         chk("m_predPC", F_predPC, e_pred);
         chk("m_halted", {63'd0, halted}, {63'd0, e_halt});
         chk("m_count", 64'(fetch_count), 64'(e_cnt));
      end
   end

   task automatic clr();
      M_icode = 4'h0; M_cnd = 1'b0; M_valA = 64'd0;
      W_icode = 4'h0; W_valM = 64'd0;
      F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0; imem_we = 1'b0;
   endtask

   initial begin
      // Program image: nop fill with directed instructions.
      for (int a = 0; a < DEPTH; a++) img[a] = 8'h10;
      img[0] = 8'h30; img[1] = 8'hF3;
      for (int a = 2; a < 9; a++) img[a] = 8'h00;
      img[9] = 8'h0A;                                   // irmovq $10,%rbx
      img[10] = 8'h60; img[11] = 8'h12;                 // addq
      img[12] = 8'h70;
      for (int a = 13; a < 20; a++) img[a] = 8'h00;
      img[20] = 8'h20;                                  // jmp 0x20
      img[32] = 8'h74;
      for (int a = 33; a < 40; a++) img[a] = 8'h00;
      img[40] = 8'h40;                                  // jne 0x40
      img[41] = 8'h20; img[42] = 8'h45;                 // rrmovq at 0x29
      img[80] = 8'hC0;                                  // invalid at 0x50
      img[112] = 8'h70;
      for (int a = 113; a < 120; a++) img[a] = 8'h00;
      img[120] = 8'h05;                                 // jmp 5 at 0x70
      img[2042] = 8'h60; img[2043] = 8'h12;             // addq at DEPTH-6
      img[2044] = 8'h30; img[2045] = 8'hF0;
      img[2046] = 8'h00; img[2047] = 8'h00;             // irmovq at DEPTH-4

      // Load memory while held in reset.
      clr();
      rst_n = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         imem_we = 1'b1; imem_waddr = AW'(a); imem_wdata = img[a];
         step();
         chk_en = 1'b1;
      end
      imem_we = 1'b0;
      step();
      chk("rst_stat", {60'd0, D_stat}, 64'd1);
      chk("rst_rA", {60'd0, D_rA}, 64'hF);
      chk("rst_pred", F_predPC, 64'd0);
      chk("rst_cnt", 64'(fetch_count), 64'd0);

      // First fetch after release.
      rst_n = 1'b1;
      step();
      chk("first_icode", {60'd0, D_icode}, 64'd3);
      chk("first_rB", {60'd0, D_rB}, 64'd3);
      chk("first_valC", D_valC, 64'h0A);
      chk("first_valP", D_valP, 64'd10);
      chk("first_pred", F_predPC, 64'd10);
      chk("first_cnt", 64'(fetch_count), 64'd1);
      step();
      step();
      chk("jmp_pred", F_predPC, 64'h20);
      step();
      chk("jne_pred", F_predPC, 64'h40);

      // Mispredict: fall-through to 0x29.
      M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h29;
      step();
      clr();
      chk("mis_icode", {60'd0, D_icode}, 64'd2);
      chk("mis_rA", {60'd0, D_rA}, 64'd4);
      chk("mis_valP", D_valP, 64'h2B);

      // Stall both registers for two cycles.
      F_stall = 1'b1; D_stall = 1'b1;
      step();
      step();
      clr();
      chk("stall_pred", F_predPC, 64'h2B);
      chk("stall_valP", D_valP, 64'h2B);
      chk("stall_cnt", 64'(fetch_count), 64'd5);

      // ret into a jmp whose target is the halt byte at 5.
      W_icode = 4'h9; W_valM = 64'h70;
      step();
      clr();
      chk("j5_pred", F_predPC, 64'd5);
      step();
      chk("hlt_stat", {60'd0, D_stat}, 64'd2);
      chk("hlt_halted", {63'd0, halted}, 64'd1);
      chk("hlt_pred", F_predPC, 64'd6);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hlt_bub_icode", {60'd0, D_icode}, 64'd1);
         chk("hlt_bub_pred", F_predPC, 64'd6);
      end
      chk("hlt_cnt", 64'(fetch_count), 64'd7);
      W_icode = 4'h9; W_valM = 64'd0;
      step();
      clr();
      chk("unhalt", {63'd0, halted}, 64'd0);
      chk("unhalt_icode", {60'd0, D_icode}, 64'd3);

      // Both redirects at once: the mispredict wins.
      M_icode = 4'h7; M_valA = 64'h4F; W_icode = 4'h9; W_valM = 64'h0A;
      step();
      clr();
      chk("prio_valP", D_valP, 64'h50);
      step();
      chk("ins_stat", {60'd0, D_stat}, 64'd4);
      chk("ins_icode", {60'd0, D_icode}, 64'hC);
      M_icode = 4'h7; M_cnd = 1'b1;       // taken jump is not a redirect
      step();
      clr();
      chk("cnd1_halted", {63'd0, halted}, 64'd1);

      // Bubble input while running.
      W_icode = 4'h9; W_valM = 64'h0A;
      step();
      clr();
      D_bubble = 1'b1;
      step();
      clr();
      chk("bub_icode", {60'd0, D_icode}, 64'd1);
      chk("bub_pred", F_predPC, 64'h20);

      // Instruction ending on the last byte, then one running off the end.
      M_icode = 4'h7; M_valA = 64'd2042;
      step();
      clr();
      chk("edge_stat", {60'd0, D_stat}, 64'd1);
      chk("edge_valP", D_valP, 64'd2044);
      step();
      chk("adr_stat", {60'd0, D_stat}, 64'd3);
      chk("adr_icode", {60'd0, D_icode}, 64'd1);
      chk("adr_halted", {63'd0, halted}, 64'd1);
      step();

      // PC entirely outside memory: redirect clears first, next fetch sets.
      M_icode = 4'h7; M_valA = 64'h1000;
      step();
      clr();
      chk("oob_stat", {60'd0, D_stat}, 64'd3);
      chk("oob_halted0", {63'd0, halted}, 64'd0);
      chk("oob_pred", F_predPC, 64'h1001);
      step();
      chk("oob_halted1", {63'd0, halted}, 64'd1);

      // Write the byte being fetched: the fetch sees the old value.
      W_icode = 4'h9; W_valM = 64'h60;
      imem_we = 1'b1; imem_waddr = AW'(11'h60); imem_wdata = 8'h00;
      step();
      clr();
      chk("wr_old_icode", {60'd0, D_icode}, 64'd1);
      chk("sat_cnt", 64'(fetch_count), 64'hF);
      step();
      W_icode = 4'h9; W_valM = 64'h60;
      step();
      clr();
      chk("wr_new_stat", {60'd0, D_stat}, 64'd2);
      step();

      // Reset overrides stall, bubble and redirect.
      rst_n = 1'b0; D_bubble = 1'b1; F_stall = 1'b1;
      M_icode = 4'h7; M_valA = 64'h29;
      step();
      chk("mrst_pred", F_predPC, 64'd0);
      chk("mrst_cnt", 64'(fetch_count), 64'd0);
      chk("mrst_icode", {60'd0, D_icode}, 64'd1);
      rst_n = 1'b1;
      clr();
      step();
      chk("mrst_first", {60'd0, D_icode}, 64'd3);
      chk("mrst_first_pred", F_predPC, 64'd10);
      step();
      step();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
